vx_mem_req_server: RTL and testbench

- Memory-side stage directly downstream of the Vortex core's memory request port. Services Vortex line reads/writes from an on-chip RAM array with fixed read latency.
- Read responses are tag-matched and buffered in a response FIFO. Back-pressure is credit-based.
- Provides a host backdoor word-write port so the bus-facing wrapper can preload kernels and data before releasing the core from reset.

---
 rtl/vx_mem_req_server.sv | 144 ++++++++++++++
 tb/tb_vx_mem_req_server.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_req_server.sv
// Memory-side server for the Vortex core memory port: on-chip line RAM with a fixed-latency read pipeline,
// an in-order tagged response FIFO, credit-based request back-pressure and a host backdoor word-write port.
module vx_mem_req_server #(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned ADDR_WIDTH     = 26,
  parameter int unsigned TAG_WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2     = 10,
  parameter int unsigned LATENCY        = 2,
  parameter int unsigned RSP_FIFO_DEPTH = 4
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              mem_req_valid,
  input  logic                                              mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0]                           mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]                             mem_req_addr,
  input  logic [DATA_WIDTH-1:0]                             mem_req_data,
  input  logic [TAG_WIDTH-1:0]                              mem_req_tag,
  output logic                                              mem_req_ready,
  output logic                                              mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]                             mem_rsp_data,
  output logic [TAG_WIDTH-1:0]                              mem_rsp_tag,
  input  logic                                              mem_rsp_ready,
  input  logic                                              host_wr_en,
  input  logic [DEPTH_LOG2+$clog2(DATA_WIDTH/32)-1:0]       host_addr,
  input  logic [31:0]                                       host_wdata
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned WORDS  = DATA_WIDTH / 32;
  localparam int unsigned LANE_W = $clog2(WORDS);
  localparam int unsigned HOST_W = DEPTH_LOG2 + LANE_W;
  localparam int unsigned LINES  = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W  = $clog2(RSP_FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(RSP_FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] ram [LINES];

  logic [LATENCY-1:0]    pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data [LATENCY];
  logic [TAG_WIDTH-1:0]  pipe_tag  [LATENCY];

  logic [DATA_WIDTH-1:0] fifo_data [RSP_FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  fifo_tag  [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      outstanding;

  logic [DEPTH_LOG2-1:0] req_line;
  logic [DEPTH_LOG2-1:0] host_line;
  logic [LANE_W-1:0]     host_lane;
  logic                  req_fire;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  push;
  logic                  pop;
  logic                  unused_addr_hi;

  // Upper line-address bits alias onto the array.
  assign req_line       = mem_req_addr[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^mem_req_addr[ADDR_WIDTH-1:DEPTH_LOG2];
  assign host_line      = host_addr[HOST_W-1:LANE_W];
  assign host_lane      = host_addr[LANE_W-1:0];

  // Credits cover every read in the pipeline plus the FIFO, so a push can never overflow.
  assign mem_req_ready = (outstanding < CNT_W'(RSP_FIFO_DEPTH)) && !host_wr_en;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rd_fire       = req_fire && !mem_req_rw;
  assign wr_fire       = req_fire && mem_req_rw;
  assign push          = pipe_valid[LATENCY-1];
  assign pop           = mem_rsp_valid && mem_rsp_ready;

  assign mem_rsp_valid = (fifo_count != '0);
  assign mem_rsp_data  = fifo_data[rd_ptr];
  assign mem_rsp_tag   = fifo_tag[rd_ptr];

  // Array and read-data pipeline; not reset so RAM contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (mem_req_byteen[b]) begin
          ram[req_line][8*b +: 8] <= mem_req_data[8*b +: 8];
        end
      end
    end
    if (host_wr_en) begin
      ram[host_line][32*int'(host_lane) +: 32] <= host_wdata;
    end
    pipe_data[0] <= ram[req_line];
    pipe_tag[0]  <= mem_req_tag;
    for (int i = 1; i < int'(LATENCY); i++) begin
      pipe_data[i] <= pipe_data[i-1];
      pipe_tag[i]  <= pipe_tag[i-1];
    end
  end

  // Read pipeline valids.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= rd_fire;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // Response FIFO and credit counter; push and pop in one cycle are both honoured.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(RSP_FIFO_DEPTH); i++) begin
        fifo_data[i] <= '0;
        fifo_tag[i]  <= '0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
        fifo_tag[wr_ptr]  <= pipe_tag[LATENCY-1];
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count  <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      outstanding <= outstanding + CNT_W'(rd_fire) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !pop && (fifo_count == CNT_W'(RSP_FIFO_DEPTH))))
        else $error("response FIFO overflow");
      assert (!(rd_fire && !pop && (outstanding == CNT_W'(RSP_FIFO_DEPTH))))
        else $error("outstanding counter overflow");
    end
  end

endmodule

// File: tb/tb_vx_mem_req_server.sv
// Directed self-checking bench for vx_mem_req_server with default parameters.
module tb_vx_mem_req_server;

  localparam int unsigned DW  = 512;
  localparam int unsigned AW  = 26;
  localparam int unsigned TW  = 8;
  localparam int unsigned HAW = 14;

  logic            clk = 1'b0;
  logic            reset;
  logic            mem_req_valid;
  logic            mem_req_rw;
  logic [DW/8-1:0] mem_req_byteen;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [TW-1:0]   mem_req_tag;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_data;
  logic [TW-1:0]   mem_rsp_tag;
  logic            mem_rsp_ready;
  logic            host_wr_en;
  logic [HAW-1:0]  host_addr;
  logic [31:0]     host_wdata;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp10;
  logic [DW-1:0] exp20;

  always #5 clk = ~clk;

  vx_mem_req_server dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .host_wr_en     (host_wr_en),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata)
  );

  function automatic logic [DW-1:0] base_line(input logic [31:0] base);
    logic [DW-1:0] v;
    for (int w = 0; w < 16; w++) v[w*32 +: 32] = base + 32'(w);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [9:0] line, input logic [3:0] lane, input logic [31:0] data);
    host_wr_en = 1'b1;
    host_addr  = {line, lane};
    host_wdata = data;
    tick();
    host_wr_en = 1'b0;
  endtask

  task automatic preload(input logic [9:0] line, input logic [31:0] base);
    for (int w = 0; w < 16; w++) host_write(line, 4'(w), base + 32'(w));
  endtask

  task automatic core_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [DW/8-1:0] be, output bit ok);
    mem_req_valid  = 1'b1;
    mem_req_rw     = 1'b1;
    mem_req_addr   = addr;
    mem_req_data   = data;
    mem_req_byteen = be;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
  endtask

  // Issues one read, returns edges from accept to rsp_valid (-1 on timeout) and the response.
  task automatic issue_read(input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                            output int lat, output logic [TW-1:0] rtag, output logic [DW-1:0] rdata);
    bit acc;
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = addr;
    mem_req_tag   = tag;
    #1;
    acc   = 1'b0;
    lat   = -1;
    rtag  = '0;
    rdata = '0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_ready) begin
        acc = 1'b1;
        break;
      end
      tick();
    end
    if (acc) begin
      tick();
      mem_req_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (mem_rsp_valid) begin
          lat = k;
          break;
        end
        tick();
      end
      rtag  = mem_rsp_tag;
      rdata = mem_rsp_data;
      if (lat >= 0) tick();
    end
    mem_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", mem_req_ready); end
    checks++;
    if (mem_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", mem_rsp_valid); end
    checks++;
    if (mem_rsp_tag !== '0) begin errors++; $display("FAIL reset_rsp_tag: got %h expected 00", mem_rsp_tag); end
    checks++;
    if (mem_rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", mem_rsp_data); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL idle_no_rsp: got rsp_valid during idle expected none"); end
  endtask

  task automatic test_host_read();
    int lat;
    logic [TW-1:0] rtag;
    logic [DW-1:0] rdata;
    preload(10'h010, 32'h1000_0000);
    host_write(10'h010, 4'd3, 32'hDEAD_BEEF);
    exp10 = base_line(32'h1000_0000);
    exp10[127:96] = 32'hDEAD_BEEF;
    issue_read(26'h010, 8'h5A, lat, rtag, rdata);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL host_read_latency: got %0d expected 2", lat); end
    checks++;
    if (rtag !== 8'h5A) begin errors++; $display("FAIL host_read_tag: got %h expected 5a", rtag); end
    checks++;
    if (rdata[127:96] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL host_read_lane3: got %h expected deadbeef", rdata[127:96]); end
    checks++;
    if (rdata !== exp10) begin errors++; $display("FAIL host_read_line: got %h expected %h", rdata, exp10); end
    checks++;
    if (mem_rsp_valid !== 1'b0) begin errors++; $display("FAIL host_read_pop: got rsp_valid %b expected 0", mem_rsp_valid); end
  endtask

  task automatic test_byteen();
    int lat;
    bit ok;
    logic [TW-1:0] rtag;
    logic [DW-1:0] rdata;
    preload(10'h020, 32'h2000_0000);
    exp20 = base_line(32'h2000_0000);
    exp20[31:0] = 32'hAAAA_AAAA;
    core_write(26'h020, {64{8'hAA}}, 64'h0000_0000_0000_000F, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL byteen_wr_accept: got no accept expected accept"); end
    issue_read(26'h020, 8'h21, lat, rtag, rdata);
    checks++;
    if (rdata !== exp20) begin errors++; $display("FAIL byteen_read: got %h expected %h", rdata, exp20); end
    checks++;
    if (lat !== 2 || rtag !== 8'h21) begin errors++; $display("FAIL byteen_rsp: got lat %0d tag %h expected lat 2 tag 21", lat, rtag); end
    core_write(26'h020, {64{8'h55}}, '0, ok);
    issue_read(26'h420, 8'h22, lat, rtag, rdata);
    checks++;
    if (rdata !== exp20) begin errors++; $display("FAIL alias_read: got %h expected %h", rdata, exp20); end
    checks++;
    if (rtag !== 8'h22) begin errors++; $display("FAIL alias_tag: got %h expected 22", rtag); end
  endtask

  task automatic test_backpressure();
    int acc;
    bit r;
    logic [TW-1:0] h_tag;
    logic [DW-1:0] h_data;
    logic [TW-1:0] got [$];
    mem_rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      mem_req_valid = (acc < 6);
      mem_req_rw    = 1'b0;
      mem_req_addr  = 26'h010;
      mem_req_tag   = TW'(acc + 1);
      #1;
      r = mem_req_ready && mem_req_valid;
      tick();
      if (r) acc++;
    end
    #1;
    checks++;
    if (acc !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", acc); end
    checks++;
    if (mem_req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", mem_req_ready); end
    checks++;
    if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== 8'h01) begin
      errors++; $display("FAIL bp_head: got valid %b tag %h expected valid 1 tag 01", mem_rsp_valid, mem_rsp_tag);
    end
    h_tag  = mem_rsp_tag;
    h_data = mem_rsp_data;
    repeat (3) tick();
    checks++;
    if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== h_tag || mem_rsp_data !== h_data) begin
      errors++; $display("FAIL bp_hold: got valid %b tag %h expected valid 1 tag %h with stable data", mem_rsp_valid, mem_rsp_tag, h_tag);
    end
    mem_rsp_ready = 1'b1;
    for (int c = 0; c < 60 && got.size() < 6; c++) begin
      mem_req_valid = (acc < 6);
      mem_req_tag   = TW'(acc + 1);
      #1;
      r = mem_req_ready && mem_req_valid;
      if (mem_rsp_valid) got.push_back(mem_rsp_tag);
      tick();
      if (r) acc++;
    end
    mem_req_valid = 1'b0;
    checks++;
    if (acc !== 6 || got.size() !== 6) begin errors++; $display("FAIL bp_total: got accepts %0d rsps %0d expected 6 and 6", acc, got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== TW'(i + 1)) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got[i], TW'(i + 1)); end
    end
  endtask

  task automatic test_host_priority();
    int lat;
    mem_rsp_ready  = 1'b1;
    host_wr_en     = 1'b1;
    host_addr      = {10'h030, 4'd5};
    host_wdata     = 32'h1234_5678;
    mem_req_valid  = 1'b1;
    mem_req_rw     = 1'b0;
    mem_req_addr   = 26'h030;
    mem_req_tag    = 8'h77;
    #1;
    checks++;
    if (mem_req_ready !== 1'b0) begin errors++; $display("FAIL prio_ready_blocked: got %b expected 0", mem_req_ready); end
    tick();
    host_wr_en = 1'b0;
    #1;
    checks++;
    if (mem_req_ready !== 1'b1) begin errors++; $display("FAIL prio_ready_after: got %b expected 1", mem_req_ready); end
    tick();
    mem_req_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (mem_rsp_valid) begin
        lat = k;
        break;
      end
      tick();
    end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL prio_latency: got %0d expected 2", lat); end
    checks++;
    if (mem_rsp_tag !== 8'h77 || mem_rsp_data[191:160] !== 32'h1234_5678) begin
      errors++; $display("FAIL prio_data: got tag %h lane5 %h expected tag 77 lane5 12345678", mem_rsp_tag, mem_rsp_data[191:160]);
    end
    tick();
  endtask

  task automatic test_reset_flush();
    bit seen;
    int lat;
    logic [TW-1:0] rtag;
    logic [DW-1:0] rdata;
    mem_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b0;
      mem_req_addr  = 26'h020;
      mem_req_tag   = 8'hE1 + TW'(i);
      tick();
    end
    mem_req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (mem_rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp_valid: got %b expected 0", mem_rsp_valid); end
    checks++;
    if (mem_req_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", mem_req_ready); end
    mem_rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL flush_stale: got a response after reset expected none"); end
    issue_read(26'h020, 8'h33, lat, rtag, rdata);
    checks++;
    if (rdata !== exp20 || rtag !== 8'h33 || lat !== 2) begin
      errors++; $display("FAIL flush_ram_kept: got lat %0d tag %h data %h expected lat 2 tag 33 data %h", lat, rtag, rdata, exp20);
    end
  endtask

  initial begin
    reset          = 1'b1;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_byteen = '0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_tag    = '0;
    mem_rsp_ready  = 1'b1;
    host_wr_en     = 1'b0;
    host_addr      = '0;
    host_wdata     = '0;
    exp10          = '0;
    exp20          = '0;
    test_reset();
    test_host_read();
    test_byteen();
    test_backpressure();
    test_host_priority();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule
